riscv_muldiv: RTL
=================

RISCV_MULDIV -- requirements
Module: riscv_muldiv

Interface
REQ-001 Parameter DATA_W, default 32: operand and result width; any even value ≥ 8 SHALL be supported.
REQ-002 Parameter TAG_W, default 5: width of the destination-register tag.
REQ-003 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; sampled only when busy=0.
REQ-006 op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 a, b  input  DATA_W each  rs1 and rs2 operands.
REQ-008 tag_in  input  TAG_W  destination register of the request.
REQ-009 flush  input  1  pipeline kill; aborts any operation in flight.
REQ-010 busy  output  1  high while an operation is in flight and new starts are refused.
REQ-011 done  output  1  single-cycle result-valid strobe.
REQ-012 result  output  DATA_W  result; valid only while done=1.
REQ-013 tag_out  output  TAG_W  tag_in captured at start; valid with done.
REQ-014 err  output  1  unsupported-operation flag; valid with done.

Function
REQ-015 The state machine SHALL have four states: IDLE, CALC, FIX, DONE.
REQ-016 start=1 with busy=0 and flush=0 SHALL latch op, a, b and tag_in.
REQ-017 After a start, the next state SHALL be CALC, or FIX on a fast path (REQ-022, REQ-023).
REQ-018 CALC SHALL run exactly DATA_W cycles under a counter.
- Multiply: shift-add on operand magnitudes into a 2*DATA_W product.
- Divide: restoring, one quotient bit per cycle.
REQ-019 FIX SHALL take one cycle, apply sign correction and select the result.
- MUL: low half of the product.
- MULH, MULHSU, MULHU: high half, with RISC-V sign rules.
- DIV/REM: quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE.
- Normal latency: done high exactly DATA_W+2 cycles after the start cycle.
REQ-021 busy SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
- A start in the DONE cycle SHALL be accepted, giving back-to-back operation.
REQ-022 Division by zero SHALL skip CALC; done at start+2.
- DIV, DIVU result: all ones. REM, REMU result: a.
REQ-023 DIV/REM with a = most-negative and b = all ones SHALL skip CALC; done at start+2.
- DIV result: a. REM result: 0.
REQ-024 flush=1 in any state SHALL force IDLE on the next edge and suppress done.
- flush with start in the same cycle: the flush wins and the start is dropped.
REQ-025 start while busy=1 SHALL be ignored with no side effects.
REQ-026 result, tag_out and err SHALL hold their last values outside done.

Reset
REQ-027 reset low SHALL asynchronously force the following, regardless of the operation in flight:
- state IDLE, busy 0, done 0, err 0;
- result 0, tag_out 0, counter 0.
REQ-028 After reset deasserts, the first rising edge SHALL be able to accept a start.

Configuration
REQ-029 Macro MULDIV_DIV_EN defined: all eight ops SHALL be implemented as specified.
REQ-030 MULDIV_DIV_EN undefined: no divider logic SHALL be synthesised.
- ops 4-7 SHALL complete at start+2 with result 0 and err=1.
- Multiply behaviour SHALL be unchanged.
- err SHALL otherwise be 0.

Verification (DATA_W=32)
REQ-031 MUL, a=7, b=0xFFFFFFFD, tag_in=9 -> done at start+34, result 0xFFFFFFEB, tag_out 9.
REQ-032 MULHU, a=b=0xFFFFFFFF -> result 0xFFFFFFFE; MULH with the same operands -> result 0.
REQ-033 DIV, a=0xFFFFFFF9, b=2 -> result 0xFFFFFFFD; REM with the same operands -> result 0xFFFFFFFF.
REQ-034 DIVU, a=5, b=0 -> done at start+2, result 0xFFFFFFFF; DIV, a=0x80000000, b=0xFFFFFFFF -> result 0x80000000.
REQ-035 MUL started, flush at start+10 -> busy 0 at start+11, no done; a start at start+11 completes normally.
REQ-036 MULDIV_DIV_EN undefined, DIV 10/2 -> done at start+2, result 0, err 1; reset asserted mid-CALC -> all outputs 0 immediately.

Source files
------------

// File: rtl/riscv_muldiv.sv
// riscv_muldiv -- iterative RV32M multiply/divide unit.
//
// One operation at a time. Multiplies use shift-add on operand magnitudes
// into a 2*DATA_W product. Divides use restoring division, one quotient
// bit per cycle. A final FIX cycle applies RISC-V sign rules.
// Normal latency: done is high DATA_W+2 cycles after the start cycle.
// Divide-by-zero and signed overflow skip CALC: done at start+2.
//
// Build option: define MULDIV_DIV_EN to include the divider.
// Without it, ops 4-7 finish at start+2 with result 0 and err=1.
//
// Handshake: a request is taken on a rising edge where
// start=1, busy=0 and flush=0. done is a one-cycle strobe.
// result, tag_out and err are valid while done=1, and hold otherwise.
// A start during the DONE cycle is accepted (back-to-back).
// flush aborts any operation and wins over a simultaneous start.
//
// Ports:
//   clk, reset (async, active-low)
//   start, op[2:0] (funct3), a, b, tag_in, flush  -- request
//   busy, done, result, tag_out, err              -- status/response
//   dbg_state[1:0]                                -- FSM state (IDLE/CALC/FIX/DONE)
module riscv_muldiv #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [TAG_W-1:0]  tag_in,
   input  logic              flush,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic [TAG_W-1:0]  tag_out,
   output logic              err,
   output logic [1:0]        dbg_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [1:0]          state;
   logic [CNT_W-1:0]    cnt;
   // Multiply: full product. Divide: {remainder, dividend/quotient}.
   logic [2*DATA_W-1:0] acc;
   logic [DATA_W-1:0]   ma_q, mb_q;
   logic [2:0]          op_q;
   logic [TAG_W-1:0]    tag_q;
   logic                neg_q;   // negate product / quotient
   logic                rneg_q;  // negate remainder
   logic                fast_q;  // acc low half already holds the result

   logic                accept;
   logic                a_sgn, b_sgn, a_neg, b_neg;
   logic [DATA_W-1:0]   a_mag, b_mag;
   logic                fast_start;
   logic [DATA_W-1:0]   fast_val;
   logic [DATA_W:0]     mul_sum;
   logic [2*DATA_W-1:0] mul_next;
   logic [2*DATA_W-1:0] mul_p;
   logic [DATA_W-1:0]   mul_res;
   logic [DATA_W-1:0]   fix_res;
   logic                fix_err;

   assign busy      = (state == S_CALC) || (state == S_FIX);
   assign done      = (state == S_DONE) && !flush;
   assign dbg_state = state;
   assign accept    = start && !busy && !flush;

   // Operand signedness: MUL/MULH/MULHSU treat a as signed, MUL/MULH treat
   // b as signed; DIV/REM treat both as signed.
   always_comb begin
      a_sgn = op[2] ? !op[0] : (op[1:0] != 2'b11);
      b_sgn = op[2] ? !op[0] : !op[1];
      a_neg = a_sgn && a[DATA_W-1];
      b_neg = b_sgn && b[DATA_W-1];
      a_mag = a_neg ? (~a + 1'b1) : a;
      b_mag = b_neg ? (~b + 1'b1) : b;
   end

   // Multiply step: add multiplicand when the low product bit is set,
   // then shift the whole product right by one.
   always_comb begin
      mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, ma_q} : '0);
      mul_next = {mul_sum, acc[DATA_W-1:1]};
      mul_p    = neg_q ? (~acc + 1'b1) : acc;
      mul_res  = (op_q[1:0] == 2'b00) ? mul_p[DATA_W-1:0] : mul_p[2*DATA_W-1:DATA_W];
   end

`ifdef MULDIV_DIV_EN
   localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
   logic                div0, ovf;
   logic [DATA_W:0]     div_trial;
   logic [2*DATA_W-1:0] div_next;
   logic [DATA_W-1:0]   quo_fix, rem_fix;

   always_comb begin
      div0       = (b == '0);
      ovf        = !op[0] && (a == MOST_NEG) && (b == '1);
      fast_start = op[2] && (div0 || ovf);
      if (div0) fast_val = op[1] ? a : '1;
      else      fast_val = op[1] ? '0 : a;
   end

   // Restoring step: trial-subtract the divisor from the shifted partial
   // remainder; keep the difference and shift in a 1 when it did not borrow.
   always_comb begin
      div_trial = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]} - {1'b0, mb_q};
      if (!div_trial[DATA_W])
         div_next = {div_trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      else
         div_next = {acc[2*DATA_W-2:0], 1'b0};
      quo_fix = neg_q  ? (~acc[DATA_W-1:0] + 1'b1) : acc[DATA_W-1:0];
      rem_fix = rneg_q ? (~acc[2*DATA_W-1:DATA_W] + 1'b1) : acc[2*DATA_W-1:DATA_W];
   end

   always_comb begin
      fix_err = 1'b0;
      if (fast_q)       fix_res = acc[DATA_W-1:0];
      else if (op_q[2]) fix_res = op_q[1] ? rem_fix : quo_fix;
      else              fix_res = mul_res;
   end
`else
   // No divider: every divide op goes straight to FIX and reports err.
   always_comb begin
      fast_start = op[2];
      fast_val   = '0;
      fix_err    = op_q[2];
      fix_res    = fast_q ? acc[DATA_W-1:0] : mul_res;
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         acc     <= '0;
         ma_q    <= '0;
         mb_q    <= '0;
         op_q    <= '0;
         tag_q   <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         fast_q  <= 1'b0;
         result  <= '0;
         tag_out <= '0;
         err     <= 1'b0;
      end else if (flush) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  op_q   <= op;
                  tag_q  <= tag_in;
                  ma_q   <= a_mag;
                  mb_q   <= b_mag;
                  neg_q  <= a_neg ^ b_neg;
                  rneg_q <= a_neg;
                  fast_q <= fast_start;
                  cnt    <= '0;
                  if (fast_start)
                     acc <= {{DATA_W{1'b0}}, fast_val};
                  else
                     acc <= {{DATA_W{1'b0}}, (op[2] ? a_mag : b_mag)};
                  state <= fast_start ? S_FIX : S_CALC;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_CALC: begin
`ifdef MULDIV_DIV_EN
               acc <= op_q[2] ? div_next : mul_next;
`else
               acc <= mul_next;
`endif
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(DATA_W - 1)) state <= S_FIX;
            end
            default: begin // S_FIX
               result  <= fix_res;
               err     <= fix_err;
               tag_out <= tag_q;
               state   <= S_DONE;
            end
         endcase
      end
   end

   // accept is the documented take condition; the case above reaches the
   // same decision through state and flush.
   logic unused_ok;
   assign unused_ok = accept;

endmodule
